// File: rtl/spi_tx_pkg.sv
// ---------------------------------------------------------------------------
// spi_tx_pkg
// Shared definitions for the SPI transmit scheduler:
//   - state_e      : frame sequencing states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   - rr_pick      : round-robin pick, request vector + pointer -> index
//   - frame_bits   : serial frame length for a given word width / requester count
// Optional feature macro: SPI_TX_CHANNEL_ID_EN (prefix each frame with the
// granted requester index, $clog2(N) bits, MSB first).
// ---------------------------------------------------------------------------
package spi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Widest requester vector rr_pick accepts; callers zero-extend into it.
  localparam int unsigned RR_MAX_N = 32;

`ifdef SPI_TX_CHANNEL_ID_EN
  localparam bit CHAN_ID_EN = 1'b1;
`else
  localparam bit CHAN_ID_EN = 1'b0;
`endif

  // First set request at or after ptr, wrapping modulo n. Returns ptr when
  // nothing is set; callers only use the result when some request is set.
  function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] req,
                                          input int unsigned          n,
                                          input int unsigned          ptr);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && req[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Number of bits shifted out per frame.
  function automatic int unsigned frame_bits(input int unsigned width,
                                             input int unsigned n);
    return width + (CHAN_ID_EN ? $clog2(n) : 0);
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// ---------------------------------------------------------------------------
// spi_shift_out
// Serialises one FRAME_W-bit word, MSB first, SPI mode 0. Owns the sclk
// divider, bit counter, shift register and the SETUP/SHIFT/HOLD timing.
//   SETUP : CLK_DIV cycles, sclk low, sdo already showing the MSB
//   SHIFT : sclk toggles every CLK_DIV cycles, FRAME_W rising edges; sdo
//           advances on every falling edge except the last
//   HOLD  : CLK_DIV cycles, sclk low
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load word and begin a frame (honoured only when idle)
//   word      : frame contents
//   done      : one-cycle pulse in the final HOLD cycle
//   sclk, sdo : serial clock / data
// ---------------------------------------------------------------------------
module spi_shift_out
  import spi_tx_pkg::*;
#(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               done,
  output logic               sclk,
  output logic               sdo
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] BIT_ALL  = CNT_W'(FRAME_W);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SETUP = ST_SETUP;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] HOLD  = ST_HOLD;

  logic [2:0]         phase;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;   // falling edges seen so far
  logic [FRAME_W-1:0] shreg;
  logic               half_end;

  assign half_end = (div_cnt == DIV_LAST);
  assign sdo      = shreg[FRAME_W-1];
  assign done     = (phase == HOLD) && half_end;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
    end else begin
      case (phase)
        IDLE: begin
          if (start) begin
            shreg   <= word;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            phase   <= SETUP;
          end
        end

        SETUP: begin
          if (half_end) begin
            div_cnt <= '0;
            sclk    <= 1'b1;       // first rising edge
            phase   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + CNT_W'(1);
              // The last bit stays on sdo through the tail and HOLD.
              if (bit_cnt != BIT_LAST)
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end else if (bit_cnt == BIT_ALL) begin
              phase <= HOLD;       // low half after the final fall is done
            end else begin
              sclk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HOLD: begin
          if (half_end) begin
            div_cnt <= '0;
            shreg   <= '0;         // sdo returns to 0 between frames
            phase   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// ---------------------------------------------------------------------------
// spi_tx_scheduler
// Shares one SPI transmit port between N requesters. Arbitrates round-robin,
// acknowledges the granted requester, drives cs and busy, and enforces the
// CS_GAP idle time between frames. Bit timing lives in spi_shift_out.
// Optional feature macro: SPI_TX_CHANNEL_ID_EN -- when defined, every frame
// starts with the granted index ($clog2(N) bits, MSB first).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester level request
//   data     : requester i word at [i*WIDTH +: WIDTH]
//   ack      : one-cycle pulse, word of requester i latched
//   busy     : high from grant until the end of the CS gap
//   cs       : chip select, active low
//   sclk     : serial clock, idle low
//   sdo      : serial data, MSB first
// ---------------------------------------------------------------------------
module spi_tx_scheduler
  import spi_tx_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
  output logic [N-1:0]       ack,
  output logic               busy,
  output logic               cs,
  output logic               sclk,
  output logic               sdo
);

  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned FRAME_W = frame_bits(WIDTH, N);
  localparam int unsigned GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // The shifter sequences SETUP/HOLD internally; SHIFT here covers the whole
  // time cs is low.
  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] GAP   = ST_GAP;

  logic [2:0]          state;
  logic [IDX_W-1:0]    ptr;
  logic [GAP_W-1:0]    gap_cnt;
  logic [IDX_W-1:0]    grant_idx;
  logic [RR_MAX_N-1:0] req_ext;
  logic                any_req;
  logic                start;
  logic                done;
  logic [WIDTH-1:0]    words [N];
  logic [FRAME_W-1:0]  frame_word;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = data[i*WIDTH +: WIDTH];
  end

  assign req_ext   = RR_MAX_N'(req);
  assign any_req   = |req;
  assign grant_idx = IDX_W'(rr_pick(req_ext, N, 32'(ptr)));
  assign start     = (state == IDLE) && any_req;

`ifdef SPI_TX_CHANNEL_ID_EN
  assign frame_word = {grant_idx, words[grant_idx]};
`else
  assign frame_word = words[grant_idx];
`endif

  spi_shift_out #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .word  (frame_word),
    .done  (done),
    .sclk  (sclk),
    .sdo   (sdo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gap_cnt <= '0;
      ack     <= '0;
      cs      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ack   <= N'(1) << grant_idx;
            cs    <= 1'b0;
            busy  <= 1'b1;
            ptr   <= (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // done marks the last HOLD cycle, so cs rises exactly at frame end.
          if (done) begin
            cs      <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_tx_scheduler
// Directed bench for spi_tx_scheduler (N=4, WIDTH=16, CLK_DIV=2, CS_GAP=4).
// Honours SPI_TX_CHANNEL_ID_EN: expected frames gain the 2-bit index prefix.
// ---------------------------------------------------------------------------
module tb_spi_tx_scheduler;

  localparam int N       = 4;
  localparam int WIDTH   = 16;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;
`ifdef SPI_TX_CHANNEL_ID_EN
  localparam int ID_W = 2;
`else
  localparam int ID_W = 0;
`endif
  localparam int FW     = WIDTH + ID_W;
  localparam int CS_LOW = (2 * FW + 2) * CLK_DIV;   // 68 default, 76 with ID

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data;
  logic [N-1:0]       ack;
  logic               busy, cs, sclk, sdo;

  logic [WIDTH-1:0]   words [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) data[i*WIDTH +: WIDTH] = words[i];
  end

  spi_tx_scheduler #(
    .N       (N),
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .ack  (ack),
    .busy (busy),
    .cs   (cs),
    .sclk (sclk),
    .sdo  (sdo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_frame(input int g);
    logic [31:0] f;
    f = 32'(words[g]);
`ifdef SPI_TX_CHANNEL_ID_EN
    f = f | (32'(g) << WIDTH);
`endif
    return f;
  endfunction

  // Waits for the next grant, then captures the frame on sclk rising edges.
  // Returns at the first negedge with cs high again (first GAP cycle).
  task automatic run_frame(input string tag, input int exp_g,
                           input bit chk_gap, input bit scramble);
    int          t, low, rises, acks;
    logic [31:0] got, exp;
    logic        prev;
    exp = exp_frame(exp_g);
    t = 0;
    while (ack == '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (ack == '0) begin
      check({tag, "_grant_timeout"}, 32'(0), 32'(1));
      return;
    end
    if (chk_gap) check({tag, "_cs_gap_min"}, 32'(t >= CS_GAP), 32'(1));
    check({tag, "_ack"}, 32'(ack), 32'(1) << exp_g);
    if (scramble) words[exp_g] = ~words[exp_g];   // must not affect this frame
    got = '0; low = 0; rises = 0; acks = 0; prev = sclk;
    while (cs == 1'b0 && low < 1000) begin
      if (ack != '0) acks++;
      if (sclk && !prev) begin
        got = {got[30:0], sdo};
        rises++;
      end
      prev = sclk;
      low++;
      @(negedge clk);
    end
    if (scramble) words[exp_g] = ~words[exp_g];
    check({tag, "_ack_cycles"}, 32'(acks), 32'(1));
    check({tag, "_cs_low"}, 32'(low), 32'(CS_LOW));
    check({tag, "_rises"}, 32'(rises), 32'(FW));
    check({tag, "_word"}, got, exp);
    check({tag, "_busy_in_gap"}, 32'(busy), 32'(1));
  endtask

  // Call with req already low: busy stays up for CS_GAP cycles, then idles.
  task automatic idle_check(input string tag);
    repeat (CS_GAP) @(negedge clk);
    check({tag, "_idle_after_gap"}, 32'({cs, sclk, sdo, busy}), 32'(4'b1000));
  endtask

  initial begin
    int t, rises;
    logic prev;

    words[0] = 16'h1357;
    words[1] = 16'hA5C3;
    words[2] = 16'h00FF;
    words[3] = 16'hC0DE;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({cs, sclk, sdo, busy}), 32'(4'b1000));
    check("reset_ack", 32'(ack), 32'(0));
    rst = 1'b0;

    // No requests: stays idle.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_no_req", 32'({cs, sclk, sdo, busy, ack}), 32'(8'b1000_0000));
    end

    // All requesting: strict 0,1,2,3,0.
    req = 4'b1111;
    run_frame("rr0", 0, 1'b0, 1'b0);
    run_frame("rr1", 1, 1'b1, 1'b0);
    run_frame("rr2", 2, 1'b1, 1'b0);
    run_frame("rr3", 3, 1'b1, 1'b0);
    run_frame("rr4", 0, 1'b1, 1'b0);
    req = '0;
    idle_check("rr");

    // Single frame from requester 1 (pointer now 1); data changes mid-frame.
    req = 4'b0010;
    run_frame("single", 1, 1'b0, 1'b1);
    req = '0;
    idle_check("single");

    // Pointer 2 -> grant 2 -> pointer 3; then wrap/skip.
    req = 4'b0100;
    run_frame("to_ptr3", 2, 1'b0, 1'b0);
    req = 4'b0101;
    run_frame("wrap_to0", 0, 1'b1, 1'b0);
    run_frame("skip_to2", 2, 1'b1, 1'b0);
    req = 4'b1001;
    run_frame("grant3", 3, 1'b1, 1'b0);
    run_frame("after3_to0", 0, 1'b1, 1'b0);
    req = '0;
    idle_check("wrap");

    // Reset mid-frame (pointer 1 -> grant 0 -> pointer would be 1).
    words[0] = 16'hFFFF;
    req = 4'b0001;
    t = 0;
    while (ack == '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("mid_ack", 32'(ack), 32'(4'b0001));
    rises = 0; prev = 1'b0; t = 0;
    while (t < 500) begin
      if (sclk && !prev) begin
        rises++;
        if (rises == 8) break;
      end
      prev = sclk;
      @(negedge clk);
      t++;
    end
    check("mid_reached_bit7", 32'(rises), 32'(8));
    check("mid_pre_reset", 32'({cs, sclk, sdo}), 32'(3'b011));
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 32'({cs, sclk, sdo, busy}), 32'(4'b1000));
    check("mid_reset_ack", 32'(ack), 32'(0));
    req = '0;
    words[0] = 16'h1357;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Pointer restarted at 0: 4'b0011 must go to 0 (would be 1 otherwise).
    req = 4'b0011;
    run_frame("post_rst_ptr0", 0, 1'b0, 1'b0);
    req = 4'b1000;
    run_frame("post_rst_req3", 3, 1'b1, 1'b0);
    req = '0;
    idle_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
Shares one serial output port (cs, sclk, sdo) between N requesters, each presenting a WIDTH-bit word.
- Grants requesters round-robin and sequences the chip-select, clock and data timing for each frame.
- Sits between the counter/sample producers and the external serial DAC/display link.
- Replaces the dedicated serializer in each producer.

Parameters:
N, 4, number of requesters (>=2)
WIDTH, 16, bits per data word (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
CS_GAP, 4, minimum clk cycles cs stays high between frames (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req  input  N  per-requester level request
data  input  N*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
ack  output  N  one-cycle pulse: word of requester i latched
busy  output  1  high from grant until end of CS_GAP
cs  output  1  chip select, active-low
sclk  output  1  serial clock, idle low (mode 0)
sdo  output  1  serial data, MSB first

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: cs=1, sclk=0, sdo=0, ack=0, busy=0, state IDLE, round-robin pointer=0, counters=0.
- Reset mid-frame aborts immediately with the same values. No partial-frame recovery.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Samples req each cycle.
  - If any bit is set, grants the first set index at or after the pointer, wrapping modulo N.
  - Next cycle: ack[g]=1 for exactly one cycle; data[g] latched into the shift register; cs=0; busy=1; sdo=MSB; pointer=(g+1) mod N. Enter SETUP.
- SETUP: lasts CLK_DIV cycles, sclk=0. Then enter SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles.
  - The receiver samples on the rising edge.
  - sdo advances to the next bit on each falling edge, except after the last bit.
  - After WIDTH rising edges and the final falling edge, enter HOLD.
- HOLD: CLK_DIV cycles, sclk=0, cs=0. Then cs=1, enter GAP.
- GAP: CS_GAP cycles with cs=1 and busy=1. Then busy=0, enter IDLE.
- cs low duration per frame: (2*WIDTH+2)*CLK_DIV cycles. Default: 68 cycles.
- req is sampled only in IDLE. Changes to req or data during a frame have no effect.
- A requester still holding req after its ack is re-granted only when the round-robin reaches it again.
- Simultaneous requests: lowest index at or after the pointer wins. With all N requesting continuously, service is strictly 0,1,..,N-1,0,...
- Single requester held high: served back-to-back, separated by CS_GAP.
- Pointer wrap: after granting N-1, pointer=0.
- No requests: remain in IDLE with outputs at their idle values.

Optional Feature:
- Macro: SPI_TX_CHANNEL_ID_EN.
- Defined: each frame is prefixed with the granted index, ID_W=$clog2(N) bits, MSB first, before the data word.
  - Frame = ID_W+WIDTH bits.
  - cs low duration = (2*(ID_W+WIDTH)+2)*CLK_DIV.
- Undefined: frame is the data word only. No ID logic synthesized.

Decomposition:
- Package spi_tx_pkg holds:
  - State enum (IDLE, SETUP, SHIFT, HOLD, GAP).
  - Round-robin pick function: req vector plus pointer -> index.
  - Frame-length constant function.
- One sub-module: spi_shift_out. It owns the sclk divider, bit counter, shift register, sdo and the SETUP/SHIFT/HOLD timing.
  - Inputs: start and word.
  - Output: done pulse.
- spi_tx_scheduler keeps arbitration, ack, cs, GAP and busy.

Test Plan:
- Reset idle: rst=1 then 0 with no req -> cs=1, sclk=0, sdo=0, busy=0 for 100 cycles.
- Single frame: req=4'b0010, data[1]=16'hA5C3 -> ack=4'b0010 for one cycle; cs low 68 cycles; 16 rising sclk edges capture 0xA5C3; cs high >=4 cycles before the next frame.
- Round-robin fairness: req=4'b1111 held, distinct words -> grant order 0,1,2,3,0; each word captured intact.
- Pointer wrap and skip: pointer at 3, req=4'b0101 -> grant 0 then 2; req=4'b1001 after granting 3 -> grant 0.
- Reset mid-frame: assert rst during bit 7 of a frame -> same cycle cs=1, sclk=0, sdo=0. After release, a frame with req=4'b1000 is granted to 3 with pointer restarted at 0.
- SPI_TX_CHANNEL_ID_EN defined, req=4'b0100, data[2]=16'h00FF -> 18 rising edges capture 2'b10 followed by 0x00FF; cs low 76 cycles.
